// File: rtl/mem_copy_engine.sv
// Two-cycle-per-word memory copy engine: READ a source word, then WRITE it to the destination.
// Define MEM_COPY_CHECKSUM_EN to add the Checksum output (running sum of copied words).
module mem_copy_engine #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    input  logic [W-1:0] MemDataOut,
    output logic [A-1:0] MemAddress,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataIn,
    output logic         Busy,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [W-1:0] Checksum,
`endif
    output logic         Done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

    state_t       state;
    logic [A-1:0] src_q;
    logic [A-1:0] dst_q;
    logic [A-1:0] len_q;
    logic [A-1:0] idx;
    logic [A-1:0] idx_next;
    logic [W-1:0] hold;

    assign idx_next = idx + ONE;

    // hold is cleared outside WRITE so it can double as the write-data output
    assign MemDataIn = hold;

    // Outputs are registered: each transition loads the values of the state being entered
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            hold       <= '0;
            MemAddress <= '0;
            MemWriteEn <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            Checksum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_q <= SrcAddr;
                        dst_q <= DstAddr;
                        len_q <= Len;
                        idx   <= '0;
                        Busy  <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                        Checksum <= '0;
`endif
                        if (Len != '0) begin
                            state      <= READ;
                            MemAddress <= SrcAddr;
                        end else begin
                            state <= FIN;
                            Done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state      <= WRITE;
                    hold       <= MemDataOut;
                    MemAddress <= dst_q + idx;
                    MemWriteEn <= 1'b1;
                end
                WRITE: begin
                    MemWriteEn <= 1'b0;
                    hold       <= '0;
                    idx        <= idx_next;
`ifdef MEM_COPY_CHECKSUM_EN
                    Checksum   <= Checksum + hold;
`endif
                    if (idx_next != len_q) begin
                        state      <= READ;
                        MemAddress <= src_q + idx_next;
                    end else begin
                        state      <= FIN;
                        MemAddress <= '0;
                        Done       <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
